// File: rtl/param_updown_stopwatch.sv
// Up/down BCD stopwatch core: IDLE/PREPARE/COUNT/RESULT sequencing, tick generator,
// LED progress bar and bounded result blink. Feeds digits, glyph and display mode to the scan driver.
module param_updown_stopwatch #(
  parameter int unsigned NDIG        = 3,
  parameter int unsigned TICK_DIV    = 1000000,
  parameter int unsigned PREP_TICKS  = 300,
  parameter int unsigned BLINK_TICKS = 100,
  parameter int unsigned BLINK_N     = 3,
  parameter int unsigned LED_W       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  output logic [4*NDIG-1:0]   bcd,
  output logic [3:0]          glyph,
  output logic [1:0]          seg_mode,
  output logic [1:0]          state,
  output logic [LED_W-1:0]    led,
  output logic                done
);

  localparam int unsigned BCD_W  = 4 * NDIG;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PREP_W = $clog2(PREP_TICKS + 1);
  localparam int unsigned BLK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned PHASES = 2 * BLINK_N;
  localparam int unsigned PH_W   = $clog2(PHASES + 1);

  localparam logic [BCD_W-1:0] ALL9 = {NDIG{4'h9}};

  localparam logic [3:0] G_P  = 4'd10;
  localparam logic [3:0] G_UP = 4'd11;
  localparam logic [3:0] G_DN = 4'd12;

  localparam logic [1:0] M_DASH  = 2'd0;
  localparam logic [1:0] M_BLANK = 2'd1;
  localparam logic [1:0] M_BCD   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PREP   = 2'd1,
    S_COUNT  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t              r_state,    w_state_nx;
  logic [BCD_W-1:0]    r_bcd,      w_bcd_nx;
  logic [3:0]          r_glyph,    w_glyph_nx;
  logic [1:0]          r_seg_mode, w_seg_nx;
  logic [LED_W-1:0]    r_led,      w_led_nx;
  logic                r_done,     w_done_nx;
  logic                r_dir_q,    w_dir_q_nx;
  logic [TICK_W-1:0]   r_tick_cnt, w_tick_nx;
  logic [PREP_W-1:0]   r_prep_cnt, w_prep_nx;
  logic [BLK_W-1:0]    r_blk_cnt,  w_blk_nx;
  logic [PH_W-1:0]     r_phase,    w_phase_nx;

  logic                w_tick;
  logic [BCD_W-1:0]    w_bcd_step;
  logic [BCD_W-1:0]    w_term;
  logic [PH_W-1:0]     w_phase_inc;

  // One BCD step with ripple carry (up) or borrow (down) across all digits.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] v, input logic up);
    logic [BCD_W-1:0] r;
    logic             c;
    logic [3:0]       d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(NDIG); i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [LED_W-1:0] msd_onehot(input logic [BCD_W-1:0] v);
    return LED_W'(1) << v[BCD_W-1 -: 4];
  endfunction

  assign w_tick      = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
  assign w_bcd_step  = bcd_step(r_bcd, r_dir_q);
  assign w_term      = r_dir_q ? ALL9 : '0;
  assign w_phase_inc = r_phase + PH_W'(1);

  assign bcd      = r_bcd;
  assign glyph    = r_glyph;
  assign seg_mode = r_seg_mode;
  assign state    = r_state;
  assign led      = r_led;
  assign done     = r_done;

  // State and datapath registers; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_bcd      <= '0;
      r_glyph    <= G_UP;
      r_seg_mode <= M_DASH;
      r_led      <= '1;
      r_done     <= 1'b0;
      r_dir_q    <= 1'b1;
      r_tick_cnt <= '0;
      r_prep_cnt <= '0;
      r_blk_cnt  <= '0;
      r_phase    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_bcd      <= w_bcd_nx;
      r_glyph    <= w_glyph_nx;
      r_seg_mode <= w_seg_nx;
      r_led      <= w_led_nx;
      r_done     <= w_done_nx;
      r_dir_q    <= w_dir_q_nx;
      r_tick_cnt <= w_tick_nx;
      r_prep_cnt <= w_prep_nx;
      r_blk_cnt  <= w_blk_nx;
      r_phase    <= w_phase_nx;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    w_state_nx = r_state;
    w_bcd_nx   = r_bcd;
    w_glyph_nx = r_glyph;
    w_seg_nx   = r_seg_mode;
    w_led_nx   = r_led;
    w_done_nx  = 1'b0;
    w_dir_q_nx = r_dir_q;
    w_prep_nx  = r_prep_cnt;
    w_blk_nx   = r_blk_cnt;
    w_phase_nx = r_phase;

    case (r_state)
      S_IDLE: begin
        w_bcd_nx   = dir ? '0 : ALL9;
        w_glyph_nx = dir ? G_UP : G_DN;
        w_seg_nx   = M_DASH;
        w_led_nx   = '1;
        if (start) begin
          w_state_nx = S_PREP;
          w_dir_q_nx = dir;
          w_glyph_nx = G_P;
          w_seg_nx   = M_BLANK;
          w_led_nx   = '0;
          w_prep_nx  = '0;
        end
      end

      S_PREP: begin
        if (w_tick) begin
          if (r_prep_cnt == PREP_W'(PREP_TICKS - 1)) begin
            w_state_nx = S_COUNT;
            w_glyph_nx = r_dir_q ? G_UP : G_DN;
            w_seg_nx   = M_BCD;
            w_led_nx   = msd_onehot(r_bcd);
          end else begin
            w_prep_nx = r_prep_cnt + PREP_W'(1);
          end
        end
      end

      S_COUNT: begin
        // stop has priority over a coincident tick, so the count freezes as displayed
        if (stop) begin
          w_state_nx = S_RESULT;
          w_led_nx   = '0;
          w_blk_nx   = '0;
          w_phase_nx = '0;
        end else if (w_tick) begin
          if (r_bcd == w_term) begin
            w_state_nx = S_RESULT;
            w_done_nx  = 1'b1;
            w_led_nx   = '0;
            w_blk_nx   = '0;
            w_phase_nx = '0;
          end else begin
            w_bcd_nx = w_bcd_step;
            w_led_nx = msd_onehot(w_bcd_step);
          end
        end
      end

      S_RESULT: begin
        if (start) begin
          w_state_nx = S_IDLE;
          w_bcd_nx   = dir ? '0 : ALL9;
          w_glyph_nx = dir ? G_UP : G_DN;
          w_seg_nx   = M_DASH;
          w_led_nx   = '1;
        end else if (w_tick && (r_phase < PH_W'(PHASES))) begin
          if (r_blk_cnt == BLK_W'(BLINK_TICKS - 1)) begin
            w_blk_nx   = '0;
            w_phase_nx = w_phase_inc;
            // odd phases are lit; once all phases have elapsed the bar stays lit
            w_led_nx   = (w_phase_inc[0] || (w_phase_inc == PH_W'(PHASES))) ? '1 : '0;
          end else begin
            w_blk_nx = r_blk_cnt + BLK_W'(1);
          end
        end
      end

      default: w_state_nx = S_IDLE;
    endcase

    w_tick_nx = ((w_state_nx != r_state) || w_tick) ? '0 : r_tick_cnt + TICK_W'(1);
  end

endmodule

// File: tb/tb_param_updown_stopwatch.sv
// Scoreboard bench for param_updown_stopwatch: a timeline model pushes every expected output
// change with its cycle; a negedge monitor pops and compares whenever the DUT outputs change.
module tb_param_updown_stopwatch;

  localparam int unsigned NDIG  = 2;
  localparam int unsigned TD    = 2;
  localparam int unsigned PREP  = 3;
  localparam int unsigned BT    = 2;
  localparam int unsigned BN    = 2;
  localparam int unsigned LED_W = 10;
  localparam int MAXV    = (10 ** NDIG) - 1;
  localparam int MSD_DIV = 10 ** (NDIG - 1);
  localparam logic [LED_W-1:0] ALL1 = '1;

  logic              clk = 1'b0;
  logic              rst_n, start, stop, dir;
  logic [4*NDIG-1:0] bcd;
  logic [3:0]        glyph;
  logic [1:0]        seg_mode, state;
  logic [LED_W-1:0]  led;
  logic              done;

  param_updown_stopwatch #(
    .NDIG(NDIG), .TICK_DIV(TD), .PREP_TICKS(PREP),
    .BLINK_TICKS(BT), .BLINK_N(BN), .LED_W(LED_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .bcd(bcd), .glyph(glyph), .seg_mode(seg_mode), .state(state),
    .led(led), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]        st;
    logic [4*NDIG-1:0] bcd;
    logic [3:0]        glyph;
    logic [1:0]        seg;
    logic [LED_W-1:0]  led;
    logic              done;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } ev_t;

  ev_t   sb[$];
  snap_t m_last;
  snap_t mprev;
  bit    mon_en = 1'b0;

  function automatic logic [4*NDIG-1:0] to_bcd(input int v);
    logic [4*NDIG-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [LED_W-1:0] bar(input int v);
    return LED_W'(1) << (v / MSD_DIV);
  endfunction

  function automatic snap_t mk(input int st, input int v, input int gl, input int sg,
                               input logic [LED_W-1:0] ld, input bit dn);
    snap_t s;
    s.st    = 2'(st);
    s.bcd   = to_bcd(v);
    s.glyph = 4'(gl);
    s.seg   = 2'(sg);
    s.led   = ld;
    s.done  = dn;
    return s;
  endfunction

  function automatic snap_t rst_snap();
    return mk(0, 0, 11, 0, ALL1, 1'b0);
  endfunction

  // Queue a required output snapshot for edge e, only when it differs from the previous one.
  function automatic void emit(input int e, input snap_t s);
    ev_t ev;
    if (s != m_last) begin
      ev.cyc = e;
      ev.s   = s;
      sb.push_back(ev);
      m_last = s;
    end
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    snap_t cur;
    ev_t   ex;
    if (mon_en) begin
      cur.st = state; cur.bcd = bcd; cur.glyph = glyph;
      cur.seg = seg_mode; cur.led = led; cur.done = done;
      if (cur != mprev) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d: got st=%0d bcd=%h glyph=%0d seg=%0d led=%h done=%b, required no change",
                   cyc, cur.st, cur.bcd, cur.glyph, cur.seg, cur.led, cur.done);
        end else begin
          ex = sb.pop_front();
          if ((ex.s != cur) || (ex.cyc != cyc)) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d st=%0d bcd=%h glyph=%0d seg=%0d led=%h done=%b, required cyc=%0d st=%0d bcd=%h glyph=%0d seg=%0d led=%h done=%b",
                     cyc, cur.st, cur.bcd, cur.glyph, cur.seg, cur.led, cur.done,
                     ex.cyc, ex.s.st, ex.s.bcd, ex.s.glyph, ex.s.seg, ex.s.led, ex.s.done);
          end
        end
        mprev = cur;
      end
    end
  end

  task automatic drv(input bit s, input bit p, input bit d);
    start = s;
    stop  = p;
    dir   = d;
    @(posedge clk);
    #2;
  endtask

  task automatic do_idle(input int n);
    bit dd, p;
    for (int i = 0; i < n; i++) begin
      dd = 1'($urandom_range(1, 0));
      p  = 1'($urandom_range(1, 0));
      emit(cyc + 1, mk(0, dd ? 0 : MAXV, dd ? 11 : 12, 0, ALL1, 1'b0));
      drv(1'b0, p, dd);
    end
  endtask

  // One full start..start cycle. to_term: run to terminal; else stop m cycles after COUNT entry.
  task automatic do_run(input bit d, input bit to_term, input int m, input int hold, input bit d_next);
    int S, C, R, X, nt, v0, vf, e, gl;
    bit s, p, dd;
    logic [LED_W-1:0] ld;
    S  = cyc + 1;
    v0 = d ? 0 : MAXV;
    gl = d ? 11 : 12;
    C  = S + int'(PREP * TD);
    if (to_term) begin
      nt = MAXV;
      R  = C + int'(TD) * (MAXV + 1);
    end else begin
      nt = (m - 1) / int'(TD);
      R  = C + m;
    end
    vf = d ? v0 + nt : v0 - nt;
    X  = R + hold;

    emit(S, mk(1, v0, 10, 1, '0, 1'b0));
    emit(C, mk(2, v0, gl, 2, bar(v0), 1'b0));
    for (int k = 1; k <= nt; k++) begin
      e = d ? v0 + k : v0 - k;
      emit(C + int'(TD) * k, mk(2, e, gl, 2, bar(e), 1'b0));
    end
    emit(R, mk(3, vf, gl, 2, '0, to_term));
    if (to_term && (R + 1 < X)) emit(R + 1, mk(3, vf, gl, 2, '0, 1'b0));
    for (int j = 1; j <= int'(2 * BN); j++) begin
      e  = R + int'(TD * BT) * j;
      ld = ((j % 2 == 1) || (j == int'(2 * BN))) ? ALL1 : '0;
      if (e < X) emit(e, mk(3, vf, gl, 2, ld, 1'b0));
    end
    emit(X, mk(0, d_next ? 0 : MAXV, d_next ? 11 : 12, 0, ALL1, 1'b0));

    for (int ee = S; ee <= X; ee++) begin
      s  = 1'b0;
      p  = 1'b0;
      dd = 1'($urandom_range(1, 0));
      if (ee == S) begin
        s  = 1'b1;
        dd = d;
        p  = 1'($urandom_range(1, 0));
      end else if (ee <= C) begin
        s = 1'($urandom_range(1, 0));
        p = 1'($urandom_range(1, 0));
      end else if (ee <= R) begin
        s = ($urandom_range(3, 0) == 0);
        p = (!to_term && (ee == R));
      end else if (ee < X) begin
        p = 1'($urandom_range(1, 0));
      end else begin
        s  = 1'b1;
        p  = 1'($urandom_range(1, 0));
        dd = d_next;
      end
      drv(s, p, dd);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_bcd"},   32'(bcd),   32'd0);
    chk({tag, "_glyph"}, 32'(glyph), 32'd11);
    chk({tag, "_seg"},   32'(seg_mode), 32'd0);
    chk({tag, "_led"},   32'(led),   32'h3FF);
    chk({tag, "_done"},  32'(done),  32'd0);
  endtask

  // Assert reset between clock edges mid-COUNT or mid-RESULT and check it acts at once.
  task automatic do_rst(input bit in_result);
    @(negedge clk);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    sb.delete();
    drv(1'b1, 1'b0, 1'b1);
    repeat (PREP * TD + 5) drv(1'b0, 1'b0, 1'b1);
    if (in_result) begin
      drv(1'b0, 1'b1, 1'b1);
      repeat (5) drv(1'b0, 1'b0, 1'b1);
      chk("pre_rst_result_state", 32'(state), 32'd3);
    end else begin
      chk("pre_rst_count_state", 32'(state), 32'd2);
    end
    #1;
    rst_n = 1'b1;
    #1;
    chk_reset_outputs(in_result ? "rst_mid_result" : "rst_mid_count");
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    m_last = rst_snap();
    mprev  = rst_snap();
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    dir   = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    m_last = rst_snap();
    mprev  = rst_snap();
    mon_en = 1'b1;

    // dir=0 in IDLE loads all nines and the DOWN glyph; stop is ignored here
    emit(cyc + 1, mk(0, MAXV, 12, 0, ALL1, 1'b0));
    drv(1'b0, 1'b0, 1'b0);
    emit(cyc + 1, mk(0, MAXV, 12, 0, ALL1, 1'b0));
    drv(1'b0, 1'b1, 1'b0);
    do_idle(4);

    do_run(1'b1, 1'b1, 0, int'(2 * BN * BT * TD) + 4, 1'b0);
    do_idle(2);
    do_run(1'b0, 1'b0, int'(TD) * (MAXV - 75 + 1), 6, 1'b1);
    do_idle(2);
    do_run(1'b0, 1'b1, 0, 3, 1'b1);
    do_run(1'b1, 1'b0, int'(TD) * 15, 1, 1'b0);
    do_idle(3);
    for (int r = 0; r < 6; r++) begin
      do_run(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
             int'($urandom_range(TD * (MAXV + 1), 1)), int'($urandom_range(24, 1)),
             1'($urandom_range(1, 0)));
      do_idle(int'($urandom_range(4, 0)));
    end

    do_rst(1'b0);
    do_idle(3);
    do_rst(1'b1);
    do_idle(5);

    @(negedge clk);
    @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending events, required 0 (next required at cyc=%0d)",
               sb.size(), sb[0].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
